uart_rx_fifo: RTL and testbench

//   Byte buffer directly downstream of the UART receiver. Captures each byte
//   on the receiver's one-cycle done strobe and holds it in a circular FIFO.

---
 rtl/uart_rx_fifo_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte path between the UART receiver, the receive FIFO and the core input port.
// The slave modport is the FIFO's view; master is the driver/consumer side.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  uart_rx_done;
    logic [7:0]            uart_rx_data;
    logic                  rd_en;
    logic                  rd_valid;
    logic [7:0]            rd_data;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    modport slave (
        input  uart_rx_done, uart_rx_data, rd_en,
        output rd_valid, rd_data, fifo_count, fifo_full, fifo_empty
    );

    modport master (
        output uart_rx_done, uart_rx_data, rd_en,
        input  rd_valid, rd_data, fifo_count, fifo_full, fifo_empty
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO behind the UART receiver; a strobed byte is at the head one cycle later.
// Full FIFO drops incoming bytes unless popped in the same cycle; UART_RX_FIFO_OVF_EN adds a sticky drop flag.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
`ifdef UART_RX_FIFO_OVF_EN
    input  logic            ovf_clr,
    output logic            ovf_flag,
`endif
    uart_rx_fifo_if.slave   fifo
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(1 << DEPTH_LOG2);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    logic [7:0]    mem [2**DEPTH_LOG2];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          push;
    logic          pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte.
    assign pop  = fifo.rd_en & ~empty_q;
    assign push = fifo.uart_rx_done & (~full_q | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ONE_C;
        if (pop)  rd_ptr_d = rd_ptr_q + ONE_C;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= fifo.uart_rx_data;
    end

    assign fifo.rd_valid   = ~empty_q;
    assign fifo.rd_data    = empty_q ? 8'd0 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign fifo.fifo_count = count_q;
    assign fifo.fifo_full  = full_q;
    assign fifo.fifo_empty = empty_q;

`ifdef UART_RX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)                     ovf_d = 1'b0;
        if (fifo.uart_rx_done && !push)  ovf_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ovf_q <= 1'b0;
        else            ovf_q <= ovf_d;
    end

    assign ovf_flag = ovf_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, full/empty corners, pointer wrap and async reset.
module tb_uart_rx_fifo;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

`ifdef UART_RX_FIFO_OVF_EN
    logic ovf_clr = 1'b0;
    logic ovf_flag;
    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ovf_clr   (ovf_clr),
        .ovf_flag  (ovf_flag),
        .fifo      (bus.slave)
    );
`else
    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .fifo      (bus.slave)
    );
`endif

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.uart_rx_done = 1'b1;
        bus.uart_rx_data = b;
        tick();
        bus.uart_rx_done = 1'b0;
    endtask

    task automatic pop_byte();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.uart_rx_done = 1'b0;
        bus.uart_rx_data = 8'h00;
        bus.rd_en        = 1'b0;
        #12;
        // 1: reset state
        check_eq("rst_valid", bus.rd_valid,   0);
        check_eq("rst_data",  bus.rd_data,    0);
        check_eq("rst_count", bus.fifo_count, 0);
        check_eq("rst_empty", bus.fifo_empty, 1);
        check_eq("rst_full",  bus.fifo_full,  0);
`ifdef UART_RX_FIFO_OVF_EN
        check_eq("rst_ovf",   ovf_flag,       0);
`endif
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        tick();

        // 2: two bytes, show-ahead, one pop
        push_byte(8'h2B);
        check_eq("t2_data1",  bus.rd_data,    8'h2B);
        check_eq("t2_cnt1",   bus.fifo_count, 1);
        check_eq("t2_valid",  bus.rd_valid,   1);
        push_byte(8'h2E);
        check_eq("t2_cnt2",   bus.fifo_count, 2);
        check_eq("t2_head",   bus.rd_data,    8'h2B);
        pop_byte();
        check_eq("t2_data2",  bus.rd_data,    8'h2E);
        check_eq("t2_cnt3",   bus.fifo_count, 1);
        pop_byte();
        check_eq("t2_empty",  bus.fifo_empty, 1);
        check_eq("t2_zero",   bus.rd_data,    0);

        // 3: fill, drop on full, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check_eq("t3_full",   bus.fifo_full,  1);
        check_eq("t3_cnt16",  bus.fifo_count, 16);
        push_byte(8'hAA);
        check_eq("t3_cntdrop", bus.fifo_count, 16);
`ifdef UART_RX_FIFO_OVF_EN
        check_eq("t3_ovf",    ovf_flag,       1);
`endif
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t3_pop%0d", i), bus.rd_data, i);
            pop_byte();
        end
        check_eq("t3_empty",  bus.fifo_empty, 1);
        check_eq("t3_cnt0",   bus.fifo_count, 0);
        check_eq("t3_valid",  bus.rd_valid,   0);

        // 4: push+pop while full
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        bus.uart_rx_done = 1'b1;
        bus.uart_rx_data = 8'h55;
        bus.rd_en        = 1'b1;
        tick();
        bus.uart_rx_done = 1'b0;
        bus.rd_en        = 1'b0;
        check_eq("t4_cnt",    bus.fifo_count, 16);
        check_eq("t4_full",   bus.fifo_full,  1);
        check_eq("t4_head",   bus.rd_data,    8'h11);
`ifdef UART_RX_FIFO_OVF_EN
        check_eq("t4_ovf",    ovf_flag,       1);
        // drop and clear together: set wins
        bus.uart_rx_done = 1'b1;
        bus.uart_rx_data = 8'h66;
        ovf_clr          = 1'b1;
        tick();
        bus.uart_rx_done = 1'b0;
        check_eq("t4_setwin", ovf_flag,       1);
        tick();
        ovf_clr = 1'b0;
        check_eq("t4_clr",    ovf_flag,       0);
        check_eq("t4_cnt2",   bus.fifo_count, 16);
`endif
        for (int i = 1; i < 16; i++) begin
            check_eq($sformatf("t4_pop%0d", i), bus.rd_data, 8'h10 + i);
            pop_byte();
        end
        check_eq("t4_last",   bus.rd_data,    8'h55);
        pop_byte();
        check_eq("t4_empty",  bus.fifo_empty, 1);

        // 5: push+pop while empty, then pop on empty alone
        bus.uart_rx_done = 1'b1;
        bus.uart_rx_data = 8'h3C;
        bus.rd_en        = 1'b1;
        tick();
        bus.uart_rx_done = 1'b0;
        bus.rd_en        = 1'b0;
        check_eq("t5_data",   bus.rd_data,    8'h3C);
        check_eq("t5_cnt",    bus.fifo_count, 1);
        pop_byte();
        pop_byte();
        check_eq("t5_cnt0",   bus.fifo_count, 0);
        check_eq("t5_empty",  bus.fifo_empty, 1);
        push_byte(8'h77);
        check_eq("t5_after",  bus.rd_data,    8'h77);
        check_eq("t5_cnt1",   bus.fifo_count, 1);
        pop_byte();

        // 6: wrap pointers with streaming push+pop, then async reset at count 5
        for (int k = 0; k < 40; k++) begin
            bus.uart_rx_done = 1'b1;
            bus.uart_rx_data = 8'(8'h80 + k);
            bus.rd_en        = 1'b1;
            tick();
        end
        bus.uart_rx_done = 1'b0;
        bus.rd_en        = 1'b0;
        check_eq("t6_cnt1",   bus.fifo_count, 1);
        check_eq("t6_head",   bus.rd_data,    8'h80 + 39);
        for (int k = 0; k < 4; k++) push_byte(8'(8'hC0 + k));
        check_eq("t6_cnt5",   bus.fifo_count, 5);
        check_eq("t6_head2",  bus.rd_data,    8'h80 + 39);
`ifdef UART_RX_FIFO_OVF_EN
        for (int k = 0; k < 11; k++) push_byte(8'hD0);
        push_byte(8'hEE);
        check_eq("t6_ovfset", ovf_flag,       1);
        for (int k = 0; k < 11; k++) pop_byte();
        check_eq("t6_cnt5b",  bus.fifo_count, 5);
`endif
        sys_rst_n = 1'b0;
        #2;
        check_eq("t6_valid",  bus.rd_valid,   0);
        check_eq("t6_data",   bus.rd_data,    0);
        check_eq("t6_count",  bus.fifo_count, 0);
        check_eq("t6_empty",  bus.fifo_empty, 1);
        check_eq("t6_full",   bus.fifo_full,  0);
`ifdef UART_RX_FIFO_OVF_EN
        check_eq("t6_ovf",    ovf_flag,       0);
`endif
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        tick();
        push_byte(8'h9A);
        check_eq("t6_post",   bus.rd_data,    8'h9A);
        check_eq("t6_postc",  bus.fifo_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
